// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter over 0..MODULUS-1 with variable step, clear/load,
// per-cycle wrap or saturate, terminal-count flags and event pulses.
module updown_counter_mod #(
   parameter int WIDTH   = 8,
   parameter int MODULUS = 256,
   parameter int STEP_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              en,
   input  logic              up_down,
   input  logic [STEP_W-1:0] step,
   input  logic              sat_mode,
   output logic [WIDTH-1:0]  count,
   output logic              at_max,
   output logic              at_min,
   output logic              ovf,
   output logic              unf,
   output logic              load_err,
   output logic              sat_seen
);

   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   // A single add/subtract of MODULUS only corrects a wrap if every step is below it.
   if (((1 << STEP_W) - 1) >= MODULUS) begin : g_step_check
      $error("updown_counter_mod: largest step (2^STEP_W-1) must be below MODULUS");
   end
   if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_mod_check
      $error("updown_counter_mod: MODULUS must lie in 2..2^WIDTH");
   end

   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   step_ext;
   logic [WIDTH:0]   sum_up;
   logic [WIDTH:0]   deficit;
   logic [WIDTH-1:0] count_next;
   logic             ovf_next;
   logic             unf_next;
   logic             load_err_next;
   logic             sat_seen_next;

   always_comb begin
      cnt_ext       = {1'b0, count};
      step_ext      = (WIDTH+1)'(step);
      sum_up        = cnt_ext + step_ext;
      deficit       = step_ext - cnt_ext;
      count_next    = count;
      ovf_next      = 1'b0;
      unf_next      = 1'b0;
      load_err_next = 1'b0;
      sat_seen_next = sat_seen;

      if (clear) begin
         count_next    = '0;
         sat_seen_next = 1'b0;
      end else if (load) begin
         if ({1'b0, load_val} < MOD_EXT) begin
            count_next = load_val;
         end else begin
            count_next    = MAX_VAL;
            load_err_next = 1'b1;
         end
      end else if (en && (step != '0)) begin
         if (up_down) begin
            if (sum_up > MAX_EXT) begin
               ovf_next = 1'b1;
               if (sat_mode) begin
                  count_next    = MAX_VAL;
                  sat_seen_next = 1'b1;
               end else begin
                  count_next = WIDTH'(sum_up - MOD_EXT);
               end
            end else begin
               count_next = WIDTH'(sum_up);
            end
         end else begin
            // Borrow case: the wrapped value is MODULUS minus the shortfall.
            if (cnt_ext < step_ext) begin
               unf_next = 1'b1;
               if (sat_mode) begin
                  count_next    = '0;
                  sat_seen_next = 1'b1;
               end else begin
                  count_next = WIDTH'(MOD_EXT - deficit);
               end
            end else begin
               count_next = WIDTH'(cnt_ext - step_ext);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         ovf      <= 1'b0;
         unf      <= 1'b0;
         load_err <= 1'b0;
         sat_seen <= 1'b0;
      end else begin
         count    <= count_next;
         ovf      <= ovf_next;
         unf      <= unf_next;
         load_err <= load_err_next;
         sat_seen <= sat_seen_next;
      end
   end

   assign at_max = (count == MAX_VAL);
   assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod at WIDTH=4, MODULUS=10, STEP_W=3: directed vector
// table, reset-mid-count sequence, and random traffic against an arithmetic model.
module tb_updown_counter_mod;

   localparam int WIDTH   = 4;
   localparam int MODULUS = 10;
   localparam int STEP_W  = 3;

   logic              clk;
   logic              reset;
   logic              clear;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic              en;
   logic              up_down;
   logic [STEP_W-1:0] step;
   logic              sat_mode;
   logic [WIDTH-1:0]  count;
   logic              at_max;
   logic              at_min;
   logic              ovf;
   logic              unf;
   logic              load_err;
   logic              sat_seen;

   updown_counter_mod #(.WIDTH(WIDTH), .MODULUS(MODULUS), .STEP_W(STEP_W)) dut (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
      .en(en), .up_down(up_down), .step(step), .sat_mode(sat_mode),
      .count(count), .at_max(at_max), .at_min(at_min), .ovf(ovf), .unf(unf),
      .load_err(load_err), .sat_seen(sat_seen)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, count=%0d", count);
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state: plain integers following the counting rules
   int m_cnt, m_sat;
   bit m_ovf, m_unf, m_lerr;

   task automatic model_reset();
      m_cnt = 0; m_sat = 0; m_ovf = 0; m_unf = 0; m_lerr = 0;
   endtask

   task automatic model_edge(input bit c, input bit l, input int lv, input bit e,
                             input bit u, input int s, input bit sm);
      m_ovf = 0; m_unf = 0; m_lerr = 0;
      if (c) begin
         m_cnt = 0; m_sat = 0;
      end else if (l) begin
         if (lv < MODULUS) m_cnt = lv;
         else begin m_cnt = MODULUS - 1; m_lerr = 1; end
      end else if (e && s != 0) begin
         if (u) begin
            if (m_cnt + s >= MODULUS) begin
               m_ovf = 1;
               if (sm) begin m_cnt = MODULUS - 1; m_sat = 1; end
               else m_cnt = (m_cnt + s) % MODULUS;
            end else m_cnt = m_cnt + s;
         end else begin
            if (m_cnt < s) begin
               m_unf = 1;
               if (sm) begin m_cnt = 0; m_sat = 1; end
               else m_cnt = (m_cnt - s + MODULUS) % MODULUS;
            end else m_cnt = m_cnt - s;
         end
      end
   endtask

   // scoreboard
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input int e_cnt, input bit e_ovf,
                            input bit e_unf, input bit e_lerr, input int e_sat);
      chk({tag, ".count"}, int'(count), e_cnt);
      chk({tag, ".at_max"}, int'(at_max), int'(e_cnt == MODULUS - 1));
      chk({tag, ".at_min"}, int'(at_min), int'(e_cnt == 0));
      chk({tag, ".ovf"}, int'(ovf), int'(e_ovf));
      chk({tag, ".unf"}, int'(unf), int'(e_unf));
      chk({tag, ".load_err"}, int'(load_err), int'(e_lerr));
      chk({tag, ".sat_seen"}, int'(sat_seen), e_sat);
   endtask

   // driver: apply one edge's inputs, advance the model, sample 1 time unit later
   task automatic drive(input bit c, input bit l, input int lv, input bit e,
                        input bit u, input int s, input bit sm);
      clear = c; load = l; load_val = WIDTH'(lv); en = e;
      up_down = u; step = STEP_W'(s); sat_mode = sm;
      @(posedge clk);
      model_edge(c, l, lv, e, u, s, sm);
      #1;
   endtask

   typedef struct {
      bit c; bit l; int lv; bit e; bit u; int s; bit sm;
      int e_cnt; bit e_ovf; bit e_unf; bit e_lerr; int e_sat;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit c, input bit l, input int lv, input bit e, input bit u,
                      input int s, input bit sm, input int ec, input bit eo,
                      input bit eu, input bit el, input int es);
      vec_t v;
      v.c = c; v.l = l; v.lv = lv; v.e = e; v.u = u; v.s = s; v.sm = sm;
      v.e_cnt = ec; v.e_ovf = eo; v.e_unf = eu; v.e_lerr = el; v.e_sat = es;
      tbl.push_back(v);
   endtask

   initial begin
      //   c  l  lv e  u  s  sm | cnt ovf unf lerr sat
      add(0, 1, 8, 0, 0, 0, 0,    8,  0,  0,  0,   0);  // wrap up
      add(0, 0, 0, 1, 1, 3, 0,    1,  1,  0,  0,   0);
      add(0, 0, 0, 1, 1, 3, 0,    4,  0,  0,  0,   0);
      add(0, 0, 0, 1, 1, 3, 0,    7,  0,  0,  0,   0);
      add(0, 0, 0, 1, 1, 3, 0,    0,  1,  0,  0,   0);
      add(0, 1, 1, 0, 0, 0, 0,    1,  0,  0,  0,   0);  // wrap down
      add(0, 0, 0, 1, 0, 2, 0,    9,  0,  1,  0,   0);
      add(0, 0, 0, 1, 0, 2, 0,    7,  0,  0,  0,   0);
      add(0, 1, 8, 0, 0, 0, 0,    8,  0,  0,  0,   0);  // saturate up
      add(0, 0, 0, 1, 1, 3, 1,    9,  1,  0,  0,   1);
      add(0, 0, 0, 1, 1, 3, 1,    9,  1,  0,  0,   1);
      add(0, 0, 0, 1, 1, 1, 1,    9,  1,  0,  0,   1);
      add(1, 0, 0, 1, 1, 1, 1,    0,  0,  0,  0,   0);
      add(1, 1, 5, 1, 1, 1, 0,    0,  0,  0,  0,   0);  // priority / load
      add(0, 1, 12, 0, 0, 0, 0,   9,  0,  0,  1,   0);
      add(0, 0, 0, 0, 1, 1, 0,    9,  0,  0,  0,   0);
      add(0, 1, 3, 1, 1, 2, 0,    3,  0,  0,  0,   0);
      add(0, 1, 4, 0, 0, 0, 0,    4,  0,  0,  0,   0);  // hold
      add(0, 0, 0, 0, 1, 1, 0,    4,  0,  0,  0,   0);
      add(0, 0, 0, 0, 0, 5, 0,    4,  0,  0,  0,   0);
      add(0, 0, 0, 0, 1, 7, 1,    4,  0,  0,  0,   0);
      add(0, 0, 0, 1, 1, 0, 0,    4,  0,  0,  0,   0);
      add(0, 0, 0, 1, 0, 0, 1,    4,  0,  0,  0,   0);
      add(0, 0, 0, 1, 1, 1, 0,    5,  0,  0,  0,   0);  // toggle direction
      add(0, 0, 0, 1, 0, 1, 0,    4,  0,  0,  0,   0);
      add(0, 0, 0, 1, 1, 1, 0,    5,  0,  0,  0,   0);
      add(0, 0, 0, 1, 0, 1, 0,    4,  0,  0,  0,   0);
      add(0, 0, 0, 1, 0, 7, 1,    0,  0,  1,  0,   1);  // saturate down
      add(0, 0, 0, 1, 0, 1, 1,    0,  0,  1,  0,   1);
      add(1, 0, 0, 0, 0, 0, 0,    0,  0,  0,  0,   0);
   end

   initial begin
      reset = 1'b0; clear = 0; load = 0; load_val = '0; en = 0;
      up_down = 0; step = '0; sat_mode = 0;
      model_reset();
      #12;
      check_all("reset", 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].c, tbl[i].l, tbl[i].lv, tbl[i].e, tbl[i].u, tbl[i].s, tbl[i].sm);
         check_all($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_unf,
                   tbl[i].e_lerr, tbl[i].e_sat);
      end

      // asynchronous reset between edges while counting
      drive(0, 1, 7, 0, 0, 0, 0);
      check_all("rst_pre", 7, 0, 0, 0, 0);
      clear = 0; load = 0; en = 1; up_down = 1; step = 3'd1; sat_mode = 0;
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all("rst_async", 0, 0, 0, 0, 0);
      #3;
      reset = 1'b1;
      drive(0, 0, 0, 1, 1, 1, 0);
      check_all("rst_resume", 1, 0, 0, 0, 0);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         bit c, l, e, u, sm;
         int lv, s;
         c  = ($urandom_range(0, 19) == 0);
         l  = ($urandom_range(0, 9) == 0);
         lv = $urandom_range(0, 15);
         e  = ($urandom_range(0, 3) != 0);
         u  = $urandom_range(0, 1);
         s  = $urandom_range(0, 7);
         sm = $urandom_range(0, 1);
         drive(c, l, lv, e, u, s, sm);
         check_all("rand", m_cnt, m_ovf, m_unf, m_lerr, m_sat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised up/down counter; successor to the fixed 4-bit up/down counter.
- Adds configurable width and modulus (count range 0..MODULUS-1).
- Adds variable step, synchronous clear and parallel load, count enable.
- Adds per-cycle wrap or saturate selection, terminal-count flags and overflow/underflow event outputs.
- Used as the general-purpose event/position counter in timers and sequencers.

Parameters:
WIDTH, 8, counter width in bits.
MODULUS, 256, count range 0..MODULUS-1; legal 2..2^WIDTH.
STEP_W, 4, width of step input; require 2^STEP_W-1 < MODULUS (elaboration-time check, $error on violation).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (asserted when 0).
clear  input  1  synchronous clear to 0.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value for load.
en  input  1  count enable.
up_down  input  1  1 = count up, 0 = count down.
step  input  STEP_W  increment/decrement amount; 0 = hold.
sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo MODULUS.
count  output  WIDTH  current count (registered).
at_max  output  1  count == MODULUS-1 (combinational from count).
at_min  output  1  count == 0 (combinational from count).
ovf  output  1  registered 1-cycle pulse: up step crossed MODULUS-1.
unf  output  1  registered 1-cycle pulse: down step crossed below 0.
load_err  output  1  registered 1-cycle pulse: load_val >= MODULUS.
sat_seen  output  1  sticky: a saturation clamp has occurred since reset/clear.

Behaviour:
- Reset (reset=0, async): count=0, ovf=unf=load_err=0, sat_seen=0. at_min=1, at_max=0. Takes effect immediately, including mid-count; first count update occurs on the first rising clk after reset deasserts.
- Per-edge priority: clear > load > en. Pulse outputs default to 0 every cycle.
- clear=1:
  - count=0, sat_seen=0.
  - load/en ignored.
- load=1 (clear=0):
  - count=load_val if load_val < MODULUS.
  - Otherwise count=MODULUS-1 and load_err=1 for one cycle.
  - en ignored.
- en=1, no clear/load, step=S:
  - S=0: hold; no pulses.
  - Up, count+S <= MODULUS-1: count += S.
  - Up, count+S > MODULUS-1:
    - wrap: count = count+S-MODULUS, ovf=1.
    - sat: count = MODULUS-1, ovf=1, sat_seen=1.
  - Down, count >= S: count -= S.
  - Down, count < S:
    - wrap: count = count+MODULUS-S, unf=1.
    - sat: count = 0, unf=1, sat_seen=1.
  - In saturate mode, a step at a bound still pulses ovf/unf and sets sat_seen. Example: at MODULUS-1, up, S=1 -> ovf=1, count unchanged.
- en=0: hold; no pulses.
- Arithmetic uses a WIDTH+1 bit intermediate; no truncation before the compare.
- Single subtraction/addition of MODULUS suffices because S < MODULUS.
- Timing: ovf/unf/load_err assert in the same cycle count shows the resulting value, i.e. latency 1 from the causing edge.
- up_down, step and sat_mode are sampled per edge; changing them any cycle is legal.
- Non-power-of-2 MODULUS: count never leaves 0..MODULUS-1 after reset.

Test Plan:
All with WIDTH=4, MODULUS=10, STEP_W=3.
- Reset mid-count: count=7, en=1, pull reset low between edges -> count=0 immediately, at_min=1; release -> counts up from 0 on the next edge.
- Wrap up: load 8, up, step=3, sat_mode=0, en=1 -> count 8 -> 1 with ovf=1 for exactly one cycle, then 4, 7, 0 (ovf=1 again).
- Wrap down: count=1, down, step=2 -> 9 with unf=1; next -> 7, unf=0.
- Saturate: count=8, up, step=3, sat_mode=1 -> 9, ovf=1, sat_seen=1, at_max=1; further edges -> stays 9 with ovf=1 each cycle; clear -> count=0, sat_seen=0.
- Priority/load: clear=1 and load=1 (load_val=5) same edge -> count=0. Then load_val=12 -> count=9, load_err=1 one cycle. load=1 with en=1, up -> count=load_val, no increment.
- Hold cases: en=0 or step=0 for 5 cycles at count=4 -> count stays 4, no pulses; toggle up_down every cycle with step=1 from 4 -> 5, 4, 5, 4.
